s_memory_decrypt: RTL
=====================

# s_memory_decrypt

RC4 keystream generator and decryptor (PRGA phase). It runs after the S-memory shuffle has finished. It reads and swaps the shuffled 256-byte S memory, XORs each keystream byte with a byte of the encrypted-message ROM, and writes the plaintext to the decrypted-message RAM. The top level muxes the S-memory port between the shuffle block and this block, and asserts `start` to this block only after the shuffle raises `finish`.

## Interface
- `MSG_LEN`, 32: message length in bytes, range 1..32. ROM/RAM addresses are `k[4:0]`.

Ports:
- `clk` input 1: single clock; all logic is rising-edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: request; sampled only in IDLE.
- `q` input 8: S-memory read data.
- `address` output 8: S-memory address.
- `data` output 8: S-memory write data.
- `write_enable` output 1: S-memory write strobe.
- `rom_address` output 5: encrypted ROM address (= k).
- `rom_q` input 8: encrypted ROM read data.
- `ram_address` output 5: decrypted RAM address (= k).
- `ram_data` output 8: decrypted RAM write data.
- `ram_write_enable` output 1: RAM write strobe.
- `finish` output 1: decryption complete.

## Operation
- Registers:
  - i, j: 8 bits, all arithmetic mod 256.
  - k: 5 bits.
  - si, sj, f: 8 bits.
- Reset, and start acceptance (IDLE with `start`=1), set i=1, j=0, k=0.
- FSM, one state per cycle:
  - IDLE: `start`=1 → RD_SI.
  - RD_SI: address=i.
  - LATCH_SI: si<=q; j<=j+q.
  - RD_SJ: address=j (new j).
  - LATCH_SJ: sj<=q.
  - WR_SI: address=i, data=sj, write_enable=1.
  - WR_SJ: address=j, data=si, write_enable=1.
  - RD_F: address=si+sj (8-bit wrap).
  - LATCH_F: f<=q; rom_q is valid this cycle and is latched.
  - WR_RAM: ram_address=k, ram_data=f^rom, ram_write_enable=1; i<=i+1; k<=k+1. If k==MSG_LEN-1 → DONE, else → RD_SI.
  - DONE: finish=1; stays while `start`=1; `start`=0 → IDLE.
- `rom_address` is driven with k at all times.
- When i==j, both swap writes hit the same address. The second write (si) wins, which leaves S unchanged. This is correct RC4 behaviour.
- `start` deasserting mid-run is ignored; the run completes.
- `start` held high after DONE does not restart. A new run needs `start` low then high.

## Timing
- Memories: registered address, unregistered output, 1-cycle read latency.
  - `q` and `rom_q` are valid the cycle after the address is driven.
  - A write at the clock edge is visible to a read address presented in the next cycle, so RD_F sees post-swap S.
- Per byte: 9 cycles. IDLE-with-start at cycle 0, first RD_SI at cycle 1, DONE entered at cycle 9·MSG_LEN+1 (289 for 32).
- Exactly one `write_enable` pulse in WR_SI and one in WR_SJ per byte. Exactly one `ram_write_enable` pulse per byte. No strobes at any other time.
- Reset values:
  - address, data, write_enable = 0.
  - ram_address, ram_data, ram_write_enable = 0.
  - finish = 0.
  - State IDLE; rom_address = 0.
- Reset asserted mid-run: at the next edge, state=IDLE, all strobes 0, finish 0, counters reinitialised. No further memory writes.
- `finish` is a level signal. It rises on the first DONE cycle and falls the cycle after `start` is seen low in DONE.

## Test plan
- Identity S (S[n]=n), ROM all 0x00, MSG_LEN=32, `start` held high:
  - RAM[0..2] = 0x02, 0x05, 0x07.
  - S[3]=5, S[5]=2 after byte 2.
  - finish rises at cycle 289.
- Same S, ROM all 0xFF → RAM[0..2] = 0xFD, 0xFA, 0xF8. RAM contents must match a golden RC4 model for all 32 bytes.
- S produced by `s_memory_shuffle` with secret_key 24'h000249, ROM = known ciphertext → RAM equals the golden plaintext; 32 RAM writes and 64 S writes total.
- Reset pulsed at cycle 40 → no writes in the following cycle; outputs return to reset values; a restart with `start` reproduces the identical RAM result.
- `start` dropped at cycle 10 → run still completes at cycle 289. Holding `start`=1 in DONE keeps finish=1 with no new writes; `start`=0 returns to IDLE.
- Strobe check on every cycle: write_enable only in WR_SI/WR_SJ, ram_write_enable only in WR_RAM, and `address` wraps mod 256 when si+sj > 255.

Source files
------------

// File: rtl/s_memory_decrypt_if.sv
// Bus bundle between the RC4 PRGA decryptor and its S memory, ciphertext ROM and plaintext RAM.
// The slave side is the decryptor; the master side is the top level that owns the memories.
interface s_memory_decrypt_if;
    logic       start;
    logic       finish;
    logic [7:0] q;
    logic [7:0] address;
    logic [7:0] data;
    logic       write_enable;
    logic [4:0] rom_address;
    logic [7:0] rom_q;
    logic [4:0] ram_address;
    logic [7:0] ram_data;
    logic       ram_write_enable;

    modport master (
        output start, q, rom_q,
        input  finish, address, data, write_enable,
        input  rom_address, ram_address, ram_data, ram_write_enable
    );

    modport slave (
        input  start, q, rom_q,
        output finish, address, data, write_enable,
        output rom_address, ram_address, ram_data, ram_write_enable
    );
endinterface

// File: rtl/s_memory_decrypt.sv
// RC4 keystream generator (PRGA): swaps entries of the shuffled S memory, XORs each keystream
// byte with the ciphertext ROM and writes the plaintext RAM, one byte every nine cycles.
module s_memory_decrypt #(
    parameter int MSG_LEN = 32
) (
    input  logic               clk,
    input  logic               reset,
    s_memory_decrypt_if.slave  bus
);

    typedef enum logic [3:0] {
        IDLE, RD_SI, LATCH_SI, RD_SJ, LATCH_SJ,
        WR_SI, WR_SJ, RD_F, LATCH_F, WR_RAM, DONE
    } state_t;

    localparam logic [4:0] LAST_K = 5'(MSG_LEN - 1);

    state_t     state_reg;
    logic [7:0] i_reg;
    logic [7:0] j_reg;
    logic [4:0] k_reg;
    logic [7:0] si_reg;
    logic [7:0] sj_reg;
    logic [7:0] f_reg;
    logic [7:0] rom_reg;
    logic [7:0] address_reg;
    logic [7:0] data_reg;
    logic       we_reg;
    logic       ram_we_reg;
    logic       finish_reg;

    // Outputs are registered one state ahead so they line up with the state that owns them;
    // the memories register the address, so read data comes back in the following LATCH_* state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            i_reg       <= 8'd1;
            j_reg       <= 8'd0;
            k_reg       <= 5'd0;
            si_reg      <= 8'd0;
            sj_reg      <= 8'd0;
            f_reg       <= 8'd0;
            rom_reg     <= 8'd0;
            address_reg <= 8'd0;
            data_reg    <= 8'd0;
            we_reg      <= 1'b0;
            ram_we_reg  <= 1'b0;
            finish_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    finish_reg <= 1'b0;
                    if (bus.start) begin
                        i_reg       <= 8'd1;
                        j_reg       <= 8'd0;
                        k_reg       <= 5'd0;
                        address_reg <= 8'd1;
                        state_reg   <= RD_SI;
                    end
                end
                RD_SI: begin
                    state_reg <= LATCH_SI;
                end
                LATCH_SI: begin
                    si_reg      <= bus.q;
                    j_reg       <= j_reg + bus.q;
                    address_reg <= j_reg + bus.q;
                    state_reg   <= RD_SJ;
                end
                RD_SJ: begin
                    state_reg <= LATCH_SJ;
                end
                LATCH_SJ: begin
                    sj_reg      <= bus.q;
                    address_reg <= i_reg;
                    data_reg    <= bus.q;
                    we_reg      <= 1'b1;
                    state_reg   <= WR_SI;
                end
                WR_SI: begin
                    // When i==j this second write lands on the same cell and restores si.
                    address_reg <= j_reg;
                    data_reg    <= si_reg;
                    we_reg      <= 1'b1;
                    state_reg   <= WR_SJ;
                end
                WR_SJ: begin
                    address_reg <= si_reg + sj_reg;
                    we_reg      <= 1'b0;
                    state_reg   <= RD_F;
                end
                RD_F: begin
                    state_reg <= LATCH_F;
                end
                LATCH_F: begin
                    f_reg      <= bus.q;
                    rom_reg    <= bus.rom_q;
                    ram_we_reg <= 1'b1;
                    state_reg  <= WR_RAM;
                end
                WR_RAM: begin
                    ram_we_reg <= 1'b0;
                    i_reg      <= i_reg + 8'd1;
                    k_reg      <= k_reg + 5'd1;
                    if (k_reg == LAST_K) begin
                        finish_reg <= 1'b1;
                        state_reg  <= DONE;
                    end else begin
                        address_reg <= i_reg + 8'd1;
                        state_reg   <= RD_SI;
                    end
                end
                DONE: begin
                    if (!bus.start) begin
                        finish_reg <= 1'b0;
                        state_reg  <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.address          = address_reg;
    assign bus.data             = data_reg;
    assign bus.write_enable     = we_reg;
    assign bus.rom_address      = k_reg;
    assign bus.ram_address      = k_reg;
    assign bus.ram_data         = f_reg ^ rom_reg;
    assign bus.ram_write_enable = ram_we_reg;
    assign bus.finish           = finish_reg;

endmodule
